// File: rtl/register_write_arbiter.sv
// Round-robin write arbiter in front of one shared enable-controlled register.
// A winner may lock ownership for a bounded burst. The lock ends on the beat
// limit, when the owner drops lock_i, or after an owner idle timeout.
module register_write_arbiter #(
  parameter int nb_bits      = 32,
  parameter int nb_req       = 4,
  parameter int max_burst    = 4,
  parameter int idle_timeout = 8
) (
  input  logic                        clock_i,
  input  logic                        reset_i,
  input  logic [nb_req-1:0]           req_i,
  input  logic [nb_req-1:0]           lock_i,
  input  logic [nb_req*nb_bits-1:0]   data_i,
  output logic [nb_req-1:0]           gnt_o,
  output logic                        reg_enable_o,
  output logic [nb_bits-1:0]          reg_data_o,
  output logic                        locked_o,
  output logic [$clog2(nb_req)-1:0]   owner_o
);

  localparam int ptr_w  = $clog2(nb_req);
  localparam int beat_w = $clog2(max_burst + 1);
  localparam int idle_w = $clog2(idle_timeout + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_r, state_nxt_s;
  logic [ptr_w-1:0]   ptr_r, ptr_nxt_s;
  logic [beat_w-1:0]  beat_r, beat_nxt_s, beat_inc_s;
  logic [idle_w-1:0]  idle_r, idle_nxt_s, idle_inc_s;
  logic [ptr_w-1:0]   owner_nxt_s;

  logic               hi_found_s, lo_found_s;
  logic [ptr_w-1:0]   hi_idx_s, lo_idx_s, winner_s;
  logic               xfer_s;
  logic [ptr_w-1:0]   xfer_idx_s;
  logic [nb_req-1:0]  gnt_s;
  logic [nb_bits-1:0] data_sel_s;

  // Index following k, wrapping from the last requester back to 0.
  function automatic logic [ptr_w-1:0] next_index(input logic [ptr_w-1:0] k);
    if (k == ptr_w'(nb_req - 1)) begin
      next_index = {ptr_w{1'b0}};
    end else begin
      next_index = k + ptr_w'(1);
    end
  endfunction

  // Round-robin scan: lowest requester at/above the pointer, else lowest overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = {ptr_w{1'b0}};
    lo_idx_s   = {ptr_w{1'b0}};
    for (int i = nb_req - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = ptr_w'(i);
        if (ptr_w'(i) >= ptr_r) begin
          hi_found_s = 1'b1;
          hi_idx_s   = ptr_w'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    winner_s = hi_found_s ? hi_idx_s : lo_idx_s;
  end

  // Grant generation: arbitration in IDLE, owner-only in LOCKED, none in reset.
  always_comb begin
    gnt_s      = {nb_req{1'b0}};
    xfer_s     = 1'b0;
    xfer_idx_s = owner_o;
    if (reset_i) begin
      xfer_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (lo_found_s) begin
            gnt_s[winner_s] = 1'b1;
            xfer_s          = 1'b1;
            xfer_idx_s      = winner_s;
          end else begin
            xfer_s = 1'b0;
          end
        end
        ST_LOCKED: begin
          gnt_s[owner_o] = req_i[owner_o];
          xfer_s         = req_i[owner_o];
          xfer_idx_s     = owner_o;
        end
        default: begin
          xfer_s = 1'b0;
        end
      endcase
    end
  end

  assign gnt_o = gnt_s;

  // Select the granted requester's word.
  always_comb begin
    data_sel_s = {nb_bits{1'b0}};
    for (int k = 0; k < nb_req; k++) begin
      if (xfer_idx_s == ptr_w'(k)) begin
        data_sel_s = data_i[k*nb_bits +: nb_bits];
      end else begin
        data_sel_s = data_sel_s;
      end
    end
  end

  // Lock bookkeeping: burst entry, beat limit, lock drop and idle timeout.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    beat_nxt_s  = beat_r;
    idle_nxt_s  = idle_r;
    owner_nxt_s = owner_o;
    beat_inc_s  = beat_r + beat_w'(1);
    idle_inc_s  = idle_r + idle_w'(1);
    case (state_r)
      ST_IDLE: begin
        if (xfer_s) begin
          owner_nxt_s = xfer_idx_s;
          if (lock_i[xfer_idx_s] && (max_burst > 1)) begin
            state_nxt_s = ST_LOCKED;
            beat_nxt_s  = beat_w'(1);
            idle_nxt_s  = {idle_w{1'b0}};
          end else begin
            ptr_nxt_s = next_index(xfer_idx_s);
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (xfer_s) begin
          beat_nxt_s = beat_inc_s;
          idle_nxt_s = {idle_w{1'b0}};
          if (!lock_i[owner_o] || (beat_inc_s == beat_w'(max_burst))) begin
            state_nxt_s = ST_IDLE;
            ptr_nxt_s   = next_index(owner_o);
            beat_nxt_s  = {beat_w{1'b0}};
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end else begin
          idle_nxt_s = idle_inc_s;
          if (idle_inc_s == idle_w'(idle_timeout)) begin
            state_nxt_s = ST_IDLE;
            ptr_nxt_s   = next_index(owner_o);
            beat_nxt_s  = {beat_w{1'b0}};
            idle_nxt_s  = {idle_w{1'b0}};
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and registered register-side outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_r      <= ST_IDLE;
      ptr_r        <= {ptr_w{1'b0}};
      beat_r       <= {beat_w{1'b0}};
      idle_r       <= {idle_w{1'b0}};
      reg_enable_o <= 1'b0;
      reg_data_o   <= {nb_bits{1'b0}};
      locked_o     <= 1'b0;
      owner_o      <= {ptr_w{1'b0}};
    end else begin
      state_r      <= state_nxt_s;
      ptr_r        <= ptr_nxt_s;
      beat_r       <= beat_nxt_s;
      idle_r       <= idle_nxt_s;
      reg_enable_o <= xfer_s;
      if (xfer_s) begin
        reg_data_o <= data_sel_s;
      end
      locked_o     <= (state_nxt_s == ST_LOCKED);
      owner_o      <= owner_nxt_s;
    end
  end

endmodule

// File: tb/tb_register_write_arbiter.sv
// Randomized bench for register_write_arbiter against a cycle-level model
// expressed directly in terms of ownership, pointer and counters.
module tb_register_write_arbiter;

  localparam int NB_BITS = 32;
  localparam int NB_REQ  = 4;
  localparam int MAXB    = 4;
  localparam int IDLE_TO = 8;

  logic                      clock_i = 1'b0;
  logic                      reset_i;
  logic [NB_REQ-1:0]         req_i;
  logic [NB_REQ-1:0]         lock_i;
  logic [NB_REQ*NB_BITS-1:0] data_i;
  logic [NB_REQ-1:0]         gnt_o;
  logic                      reg_enable_o;
  logic [NB_BITS-1:0]        reg_data_o;
  logic                      locked_o;
  logic [1:0]                owner_o;

  register_write_arbiter #(
    .nb_bits(NB_BITS), .nb_req(NB_REQ), .max_burst(MAXB), .idle_timeout(IDLE_TO)
  ) dut (
    .clock_i(clock_i), .reset_i(reset_i), .req_i(req_i), .lock_i(lock_i),
    .data_i(data_i), .gnt_o(gnt_o), .reg_enable_o(reg_enable_o),
    .reg_data_o(reg_data_o), .locked_o(locked_o), .owner_o(owner_o)
  );

  always #5 clock_i = ~clock_i;

  int checks   = 0;
  int failures = 0;

  // Reference state
  bit          m_locked;
  int          m_owner, m_ptr, m_beats, m_idle;
  logic        m_en;
  logic [31:0] m_data;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Winner index, or -1 when nobody is granted.
  function automatic int model_grant();
    if (reset_i) return -1;
    if (m_locked) return req_i[m_owner] ? m_owner : -1;
    for (int j = 0; j < NB_REQ; j++) begin
      int k;
      k = (m_ptr + j) % NB_REQ;
      if (req_i[k]) return k;
    end
    return -1;
  endfunction

  task automatic model_step(input int g);
    if (reset_i) begin
      m_locked = 0; m_ptr = 0; m_beats = 0; m_idle = 0;
      m_en = 1'b0; m_data = 32'h0; m_owner = 0;
    end else begin
      m_en = (g >= 0);
      if (g >= 0) begin
        m_data  = data_i[g*NB_BITS +: NB_BITS];
        m_owner = g;
      end
      if (!m_locked) begin
        if (g >= 0) begin
          if (lock_i[g] && MAXB > 1) begin
            m_locked = 1; m_beats = 1; m_idle = 0;
          end else begin
            m_ptr = (g + 1) % NB_REQ;
          end
        end
      end else if (g >= 0) begin
        m_beats++;
        m_idle = 0;
        if (!lock_i[m_owner] || m_beats == MAXB) begin
          m_locked = 0;
          m_ptr = (m_owner + 1) % NB_REQ;
        end
      end else begin
        m_idle++;
        if (m_idle == IDLE_TO) begin
          m_locked = 0;
          m_ptr = (m_owner + 1) % NB_REQ;
        end
      end
    end
  endtask

  task automatic run_cycle(input logic rst, input logic [NB_REQ-1:0] req,
                           input logic [NB_REQ-1:0] lock);
    int g;
    logic [NB_REQ-1:0] exp_gnt;
    @(negedge clock_i);
    reset_i = rst;
    req_i   = req;
    lock_i  = lock;
    for (int k = 0; k < NB_REQ; k++) data_i[k*NB_BITS +: NB_BITS] = $urandom();
    #1;
    g = model_grant();
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    check_value("gnt", 64'(gnt_o), 64'(exp_gnt));
    model_step(g);
    @(posedge clock_i);
    #1;
    check_value("reg_enable", 64'(reg_enable_o), 64'(m_en));
    check_value("reg_data", 64'(reg_data_o), 64'(m_data));
    check_value("locked", 64'(locked_o), 64'(m_locked));
    check_value("owner", 64'(owner_o), 64'(m_owner));
  endtask

  initial begin
    int preq[NB_REQ];
    int plock[NB_REQ];
    logic [NB_REQ-1:0] r, l;
    reset_i = 1'b1;
    req_i   = '0;
    lock_i  = '0;
    data_i  = '0;
    m_locked = 0; m_owner = 0; m_ptr = 0; m_beats = 0; m_idle = 0;
    m_en = 1'b0; m_data = 32'h0;

    run_cycle(1'b1, 4'b0000, 4'b0000);
    run_cycle(1'b1, 4'b0000, 4'b0000);
    for (int i = 0; i < 5; i++) run_cycle(1'b0, 4'b0000, 4'b0000);
    // All requesting, no locks: pure rotation.
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 4'b1111, 4'b0000);
    // Requester 2 locks while 0 competes: beat limit.
    for (int i = 0; i < 6; i++) run_cycle(1'b0, 4'b0101, 4'b0100);
    // Requester 1 locks then goes quiet while 3 waits: idle timeout.
    run_cycle(1'b0, 4'b0010, 4'b0010);
    for (int i = 0; i < 11; i++) run_cycle(1'b0, 4'b1000, 4'b0000);
    // Reset in the middle of a burst.
    run_cycle(1'b0, 4'b0001, 4'b0001);
    run_cycle(1'b0, 4'b0001, 4'b0001);
    run_cycle(1'b1, 4'b1111, 4'b1111);
    run_cycle(1'b0, 4'b1111, 4'b0000);

    // Randomized phases with per-requester activity and lock biases.
    for (int ph = 0; ph < 60; ph++) begin
      for (int k = 0; k < NB_REQ; k++) begin
        preq[k]  = $urandom_range(0, 100);
        plock[k] = $urandom_range(0, 100);
      end
      for (int c = 0; c < 30; c++) begin
        for (int k = 0; k < NB_REQ; k++) begin
          r[k] = ($urandom_range(0, 99) < preq[k]);
          l[k] = ($urandom_range(0, 99) < plock[k]);
        end
        run_cycle(($urandom_range(0, 149) == 0), r, l);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_write_arbiter.md
Name: register_write_arbiter

Overview:
- Shares one enable-controlled storage register between nb_req requesters.
- Each requester presents a word with a req/gnt handshake. The arbiter selects one winner per cycle by round-robin and drives the register's data and enable inputs, one cycle registered.
- A requester may lock the register for a short burst of consecutive writes. The lock is bounded by a beat limit and by an idle timeout.
- Sits directly in front of the shared register, in the same clock domain.

Parameters:
- nb_bits, 32: width of each data word and of the register.
- nb_req, 4: number of requesters, at least 2.
- max_burst, 4: maximum transfers per locked ownership, at least 1.
- idle_timeout, 8: consecutive owner-idle cycles that force a lock release, at least 1.

Ports:
- clock_i  in  1  rising-edge clock.
- reset_i  in  1  synchronous, active-high reset.
- req_i  in  nb_req  per-requester write request.
- lock_i  in  nb_req  per-requester request to keep ownership after the current transfer.
- data_i  in  nb_req*nb_bits  requester k word in bits [k*nb_bits +: nb_bits].
- gnt_o  out  nb_req  combinational one-hot grant; transfer of k occurs in a cycle with req_i[k] and gnt_o[k] both high.
- reg_enable_o  out  1  enable to the shared register, registered.
- reg_data_o  out  nb_bits  data to the shared register, registered.
- locked_o  out  1  high while in LOCKED, registered.
- owner_o  out  $clog2(nb_req)  current or last owner index, registered.

Behaviour:
- Reset: while reset_i is high, gnt_o is 0 (forced combinationally). On the edge with reset_i high:
  - state = IDLE, rr pointer = 0, beat count = 0, idle count = 0;
  - reg_enable_o = 0, reg_data_o = 0, locked_o = 0, owner_o = 0.
  - A reset mid-burst abandons the lock; no further write is issued.
- Grant in IDLE: the winner is the first k with req_i[k] high, scanning from the pointer upward with wrap (nb_req-1 is followed by 0). gnt_o = onehot(winner), or 0 if no requests.
- Grant in LOCKED: gnt_o[owner] = req_i[owner]; all other grant bits are 0, whatever their requests.
- Transfer effect: on the next edge, reg_data_o <= data of the granted requester, reg_enable_o <= 1, owner_o <= granted index. Latency from transfer cycle to register input is 1 cycle, so the register captures on the edge after that.
- No transfer in a cycle: reg_enable_o <= 0 and reg_data_o holds its value.
- IDLE transfer by k:
  - lock_i[k] high and max_burst > 1: go to LOCKED, beat count = 1, idle count = 0.
  - Otherwise: stay IDLE, pointer <= k+1 mod nb_req.
- LOCKED transfer: beat count increments. Release to IDLE, with pointer <= owner+1 mod nb_req, when either holds:
  - lock_i[owner] is low in that transfer cycle;
  - the incremented beat count equals max_burst (that transfer is the last).
- LOCKED cycle without owner request: idle count increments. When it reaches idle_timeout, release to IDLE with pointer <= owner+1 on that edge. Any owner transfer clears the idle count.
- Release is registered. In the cycle right after release, IDLE arbitration applies, so a waiting requester can be granted immediately.
- lock_i is ignored in LOCKED for non-owners and in IDLE for non-winners.
- Simultaneous requests are resolved only by the pointer; there is no fixed priority.
- data_i of non-granted requesters is don't-care.

Test Plan:
- Reset, then all req_i low for 5 cycles -> gnt_o = 0, reg_enable_o = 0, reg_data_o = 0, locked_o = 0.
- Pointer 0, req_i = 4'b1111 held, lock_i = 0:
  - grants must be 0,1,2,3,0 on consecutive cycles;
  - each cycle after a grant: reg_enable_o = 1 and reg_data_o equals that requester's word (0x11111111, 0x22222222, 0x33333333, 0x44444444).
- Requester 2 with req and lock held, requester 0 requesting, max_burst = 4, first word 0xDEADBEEF:
  - exactly 4 consecutive grants to 2, locked_o high;
  - grant then moves to 0 on the following cycle;
  - reg_data_o = 0xDEADBEEF one cycle after the first beat.
- Requester 1 locks, then drops req_i[1] while requester 3 requests, idle_timeout = 8 -> gnt_o[3] stays 0 for 8 cycles, then locked_o falls and requester 3 is granted next.
- Requester 1 transfers with lock_i[1] low on its second beat -> release after 2 beats; pointer = 2.
- Reset asserted mid-burst (after beat 2 of 4) -> reg_enable_o = 0 on the next edge, locked_o = 0, and the next arbitration starts at requester 0.
